vga_text_pixel_gen: RTL and testbench
=====================================

Name: vga_text_pixel_gen

Overview:
- Text-mode pixel generator for the VGA path, directly upstream of the palette controller.
- Converts timing-generator pixel coordinates into text-buffer and font-ROM reads.
- Outputs a per-pixel 4-bit fg/bg colour index pair for the palette.
- Delays hsync/vsync/de so they stay aligned with the palette's fixed 2-cycle RGB latency.

Parameters:
- COLS, 80, characters per row; text address = row*COLS+col.
- ROWS, 30, character rows; rows >= ROWS read as blank.
- PAL_LAT, 2, palette controller latency, added to the sync delay line.
- SYNC_ACTIVE, 0, active level of hsync/vsync; reset drives the inactive level.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- h_cnt  in  10  pixel column from timing generator.
- v_cnt  in  10  pixel line from timing generator.
- de_in  in  1  display-enable (visible area).
- hsync_in  in  1  horizontal sync, SYNC_ACTIVE polarity.
- vsync_in  in  1  vertical sync, SYNC_ACTIVE polarity.
- txt_addr  out  12  text RAM read address.
- txt_data  in  16  text RAM data, 1-cycle synchronous read; [7:0]=char, [11:8]=fg, [15:12]=bg.
- font_addr  out  12  font ROM address {char, glyph_row[3:0]}.
- font_data  in  8  font ROM byte, 1-cycle synchronous read; bit 7 = leftmost pixel.
- fg  out  4  colour index to palette: attr_fg if glyph bit set, else attr_bg.
- bg  out  4  attr_bg to palette.
- hsync_out  out  1  hsync delayed 5+PAL_LAT cycles.
- vsync_out  out  1  vsync delayed 5+PAL_LAT cycles.
- de_out  out  1  de delayed 5+PAL_LAT cycles.

Behaviour:
- Reset (async, rst_n=0):
  - txt_addr, font_addr, fg, bg and de_out go to 0.
  - hsync_out and vsync_out go to ~SYNC_ACTIVE.
  - All pipeline registers and the delay line clear, with sync taps at the inactive level.
- Reset release mid-frame: the first 5+PAL_LAT outputs are the reset values; no glitch pulse on sync.
- Pipeline, with T0 = inputs sampled:
  - T1: txt_addr registered. col=h_cnt[9:3], row=v_cnt[8:4], addr=(row<<6)+(row<<4)+col for COLS=80. Address = 0 if de_in=0 or row>=ROWS. Also registered at T1: x[2:0], y[3:0], blank flag.
  - T2: txt_data valid; attribute registered.
  - T3: font_addr registered as {char, y[3:0]}; fg/bg attribute carried forward.
  - T4: font_data valid.
  - T5: fg/bg registered.
- Pixel selection at T5: bit = font_data[7-x[2:0]]. Blank (de=0 or row>=ROWS) forces fg=bg=0.
- Latency: fg/bg are valid 5 cycles after coordinates. Sync/de delay is 5+PAL_LAT cycles (7 by default), so they align with palette RGB.
- The delay line is a shift register for hsync, vsync and de. Side-band x/y/blank travel with the data pipeline.
- No handshake: free-running, one pixel per clk. Back-to-back cells switch attribute on the exact pixel where x wraps 7->0.
- Wrap: col=79 to 0 at line end and row 29 to 0 at frame end need no special handling. Addresses never exceed COLS*ROWS-1 = 2399.

Optional Feature:
VGA_CURSOR_EN
- When defined, adds these ports:
  - cursor_x  in  7  cursor column.
  - cursor_y  in  5  cursor row.
  - cursor_on  in  1  cursor enable.
- Adds a 5-bit frame counter that increments on each vsync_in transition into SYNC_ACTIVE. Reset value is 0.
- Cursor is shown when cursor_on=1, the cell matches (col,row), y[3:0] >= 14 and frame_cnt[4]=1. It then forces fg=attr_fg regardless of the glyph bit.
- Blink period is 32 frames.
- Cursor match is pipelined alongside the data so the latency is unchanged.
- Without the macro: no cursor ports, no counter; fg/bg depend only on glyph and attribute.

Decomposition:
- Package vga_text_pkg:
  - Constants: COLS, ROWS, CHAR_W=8, CHAR_H=16, PIPE_LAT=5.
  - Field slices for the txt_data attribute: CHAR, FG, BG.
  - Text address width 12.
- Sub-module vga_sync_delay:
  - Parameterised-depth shift register for {hsync, vsync, de}.
  - Reset value input chooses the inactive sync level.

Test Plan:
- Reset: rst_n=0 mid-line -> fg=bg=0, de_out=0, hsync_out=vsync_out=1; after release, first 7 outputs keep those values.
- Address: h_cnt=639, v_cnt=479, de=1 -> txt_addr=29*80+79=2399 at T1. de=0 -> txt_addr=0.
- Glyph: txt_data=0x1A41, font_data=0x81 for 8 pixels of cell (0,0) -> fg sequence A,1,1,1,1,1,1,A starting at T5; bg=1 throughout.
- Alignment: single-cycle hsync_in pulse at cycle 100 -> hsync_out pulse at cycle 107. de_out rises exactly 2 cycles after the first non-blank fg.
- Blank: v_cnt=480 (row 30) with de_in=1 -> fg=bg=0 for the whole line.
- Cursor (VGA_CURSOR_EN): cursor at (3,2), cursor_on=1, font_data=0x00, attr fg=0xF, after 16 vsyncs -> fg=F on glyph rows 14-15 of cell (3,2) only; after 32 vsyncs -> fg=bg.

Source files
------------

// File: rtl/vga_text_pkg.sv
// Shared constants and field layout for the VGA text-mode pixel path.
package vga_text_pkg;

    localparam int COLS     = 80;   // characters per row
    localparam int ROWS     = 30;   // character rows
    localparam int CHAR_W   = 8;    // glyph width in pixels
    localparam int CHAR_H   = 16;   // glyph height in lines
    localparam int PIPE_LAT = 5;    // coordinates -> fg/bg latency
    localparam int TXT_AW   = 12;   // text RAM address width

    // Text RAM word: [7:0] character code, [11:8] fg index, [15:12] bg index.
    typedef struct packed {
        logic [3:0] bg;
        logic [3:0] fg;
        logic [7:0] chr;
    } txt_word_t;

endpackage

// File: rtl/vga_sync_delay.sv
// Shift-register delay line for the {hsync, vsync, de} side-band.
// Every tap resets to rst_val so no sync pulse can leak out after reset.
module vga_sync_delay #(
    parameter int DEPTH = 7,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] taps [DEPTH];

    // Shift one tap per pixel clock; all taps load the inactive level on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) taps[i] <= rst_val;
        end else begin
            taps[0] <= d;
            for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
        end
    end

    assign q = taps[DEPTH-1];

endmodule

// File: rtl/vga_text_pixel_gen.sv
// Text-mode pixel generator: timing coordinates -> text RAM -> font ROM ->
// per-pixel fg/bg colour indices, with sync/de delayed to match the palette.
// Free-running, one pixel per clock, no handshake.
// Optional blinking block cursor when VGA_CURSOR_EN is defined.
module vga_text_pixel_gen #(
    parameter int   COLS        = vga_text_pkg::COLS,
    parameter int   ROWS        = vga_text_pkg::ROWS,
    parameter int   PAL_LAT     = 2,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef VGA_CURSOR_EN
    input  logic [6:0]  cursor_x,
    input  logic [4:0]  cursor_y,
    input  logic        cursor_on,
`endif
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [11:0] txt_addr,
    input  logic [15:0] txt_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [3:0]  fg,
    output logic [3:0]  bg,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        de_out
);

    import vga_text_pkg::*;

    localparam int DLY = PIPE_LAT + PAL_LAT;

    // T0 decode of the incoming coordinates
    logic [6:0] col;
    logic [4:0] row;
    logic       blank0;

    assign col    = h_cnt[9:3];
    assign row    = v_cnt[8:4];
    assign blank0 = !de_in || (v_cnt[9:4] >= 6'(ROWS));

    // Pipeline side-band: pixel-in-cell x, glyph row y, blank flag, attributes
    logic [2:0] x1, x2, x3, x4;
    logic [3:0] y1, y2;
    logic       blank1, blank2, blank3, blank4;
    logic [3:0] attr_fg3, attr_bg3, attr_fg4, attr_bg4;
    txt_word_t  word;
    logic       pix;
    logic       cur_hit;

    assign word = txt_data;

    // T1: text address plus the side-band that follows the data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txt_addr <= '0;
            x1       <= '0;
            y1       <= '0;
            blank1   <= 1'b1;
        end else begin
            txt_addr <= blank0 ? 12'd0 : (12'(row) * 12'(COLS) + 12'(col));
            x1       <= h_cnt[2:0];
            y1       <= v_cnt[3:0];
            blank1   <= blank0;
        end
    end

    // T2..T4: carry side-band, issue the font read and hold the attribute
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x2        <= '0;
            y2        <= '0;
            blank2    <= 1'b1;
            x3        <= '0;
            blank3    <= 1'b1;
            font_addr <= '0;
            attr_fg3  <= '0;
            attr_bg3  <= '0;
            x4        <= '0;
            blank4    <= 1'b1;
            attr_fg4  <= '0;
            attr_bg4  <= '0;
        end else begin
            x2        <= x1;
            y2        <= y1;
            blank2    <= blank1;
            x3        <= x2;
            blank3    <= blank2;
            font_addr <= {word.chr, y2};
            attr_fg3  <= word.fg;
            attr_bg3  <= word.bg;
            x4        <= x3;
            blank4    <= blank3;
            attr_fg4  <= attr_fg3;
            attr_bg4  <= attr_bg3;
        end
    end

    // Leftmost pixel of the glyph byte is bit 7
    assign pix = font_data[3'd7 - x4];

`ifdef VGA_CURSOR_EN
    logic [4:0] frame_cnt;
    logic       vsync_q;
    logic       cur0, cur1, cur2, cur3, cur4;

    // Frame counter for the blink: counts vsync entries into the active level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q   <= ~SYNC_ACTIVE;
            frame_cnt <= '0;
        end else begin
            vsync_q <= vsync_in;
            if (vsync_in == SYNC_ACTIVE && vsync_q != SYNC_ACTIVE)
                frame_cnt <= frame_cnt + 5'd1;
        end
    end

    // Cursor covers the bottom two glyph lines of its cell, on half the blink
    assign cur0 = cursor_on && (col == cursor_x) && (row == cursor_y) &&
                  (v_cnt[3:0] >= 4'd14) && frame_cnt[4];

    // Cursor match travels with the data so latency is unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur1 <= 1'b0;
            cur2 <= 1'b0;
            cur3 <= 1'b0;
            cur4 <= 1'b0;
        end else begin
            cur1 <= cur0;
            cur2 <= cur1;
            cur3 <= cur2;
            cur4 <= cur3;
        end
    end

    assign cur_hit = cur4;
`else
    assign cur_hit = 1'b0;
`endif

    // T5: colour selection; blank forces both indices to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fg <= '0;
            bg <= '0;
        end else if (blank4) begin
            fg <= '0;
            bg <= '0;
        end else begin
            fg <= (pix || cur_hit) ? attr_fg4 : attr_bg4;
            bg <= attr_bg4;
        end
    end

    logic [2:0] dly_q;

    vga_sync_delay #(
        .DEPTH (DLY),
        .WIDTH (3)
    ) u_sync_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .rst_val ({~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0}),
        .d       ({hsync_in, vsync_in, de_in}),
        .q       (dly_q)
    );

    assign hsync_out = dly_q[2];
    assign vsync_out = dly_q[1];
    assign de_out    = dly_q[0];

endmodule

// File: tb/tb_vga_text_pixel_gen.sv
// Bench for vga_text_pixel_gen: table-driven address and pixel streams,
// plus hand-written sync alignment, reset-release and cursor sequences.
module tb_vga_text_pixel_gen;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  h_cnt, v_cnt;
    logic        de_in, hsync_in, vsync_in;
    logic [11:0] txt_addr, font_addr;
    logic [15:0] txt_data;
    logic [7:0]  font_data;
    logic [3:0]  fg, bg;
    logic        hsync_out, vsync_out, de_out;
`ifdef VGA_CURSOR_EN
    logic [6:0]  cursor_x  = 7'd3;
    logic [4:0]  cursor_y  = 5'd2;
    logic        cursor_on = 1'b1;
`endif

    always #5 clk = ~clk;

    vga_text_pixel_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef VGA_CURSOR_EN
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .cursor_on (cursor_on),
`endif
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .de_in     (de_in),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .txt_addr  (txt_addr),
        .txt_data  (txt_data),
        .font_addr (font_addr),
        .font_data (font_data),
        .fg        (fg),
        .bg        (bg),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .de_out    (de_out)
    );

    // Text RAM and font ROM models with 1-cycle synchronous read
    logic [15:0] tmem [4096];
    logic [7:0]  fmem [4096];

    always @(posedge clk) begin
        txt_data  <= tmem[txt_addr];
        font_data <= fmem[font_addr];
    end

    // ---------------- scoreboard ----------------
    int pass_cnt  = 0;
    int check_cnt = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " txt_addr"},  16'(txt_addr),  16'd0);
        check({tag, " font_addr"}, 16'(font_addr), 16'd0);
        check({tag, " fg"},        16'(fg),        16'd0);
        check({tag, " bg"},        16'(bg),        16'd0);
        check({tag, " de_out"},    16'(de_out),    16'd0);
        check({tag, " hsync_out"}, 16'(hsync_out), 16'd1);
        check({tag, " vsync_out"}, 16'(vsync_out), 16'd1);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input int h, input int v, input logic de, input logic hs, input logic vs);
        h_cnt    = 10'(h);
        v_cnt    = 10'(v);
        de_in    = de;
        hsync_in = hs;
        vsync_in = vs;
    endtask

    task automatic drive_idle();
        drive(700, 0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic clean_reset();
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        de;
        logic [11:0] addr;
    } addr_vec_t;

    typedef struct {
        logic [9:0] h;
        logic [9:0] v;
        logic       de;
        logic [3:0] fg;
        logic [3:0] bg;
    } pix_vec_t;

    addr_vec_t av [7];
    pix_vec_t  pv [40];
    int        nv;

    function automatic pix_vec_t mkv(input int h, input int v, input logic de,
                                     input logic [3:0] f, input logic [3:0] b);
        pix_vec_t r;
        r.h  = 10'(h);
        r.v  = 10'(v);
        r.de = de;
        r.fg = f;
        r.bg = b;
        return r;
    endfunction

    // Stream pv[0..nv-1] one per clock; fg/bg appear 5 edges after capture
    task automatic run_stream(input string tag);
        logic [7:0] e;
        for (int c = 0; c < nv + 4; c++) begin
            @(negedge clk);
            if (c < nv) begin
                drive(int'(pv[c].h), int'(pv[c].v), pv[c].de, 1'b1, 1'b1);
                exp_q.push_back({pv[c].fg, pv[c].bg});
            end else begin
                drive_idle();
            end
            @(posedge clk);
            #1;
            if (c >= 4) begin
                e = exp_q.pop_front();
                check($sformatf("%s fg[%0d]", tag, c - 4), 16'(fg), 16'(e[7:4]));
                check($sformatf("%s bg[%0d]", tag, c - 4), 16'(bg), 16'(e[3:0]));
            end
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] seq;

        for (int i = 0; i < 4096; i++) begin
            tmem[i] = 16'h0000;
            fmem[i] = 8'h00;
        end
        tmem[0]    = 16'h1A41;   // 'A', fg A, bg 1
        tmem[1]    = 16'h2C42;   // 'B', fg C, bg 2
        tmem[2322] = 16'h5643;   // row 29 col 2: 'C', fg 6, bg 5
        tmem[162]  = 16'h3F00;   // row 2 cols 2..4: char 0, fg F, bg 3
        tmem[163]  = 16'h3F00;
        tmem[164]  = 16'h3F00;
        fmem[12'h410] = 8'h81;
        fmem[12'h415] = 8'h3C;
        fmem[12'h420] = 8'hF0;
        fmem[12'h43F] = 8'h80;

        // Reset held mid-line
        rst_n = 1'b0;
        drive(100, 0, 1'b1, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive_idle();
        repeat (10) @(negedge clk);

        // Address table
        av[0] = '{10'd639, 10'd479, 1'b1, 12'd2399};
        av[1] = '{10'd639, 10'd479, 1'b0, 12'd0};
        av[2] = '{10'd0,   10'd0,   1'b1, 12'd0};
        av[3] = '{10'd8,   10'd16,  1'b1, 12'd81};
        av[4] = '{10'd639, 10'd16,  1'b1, 12'd159};
        av[5] = '{10'd100, 10'd480, 1'b1, 12'd0};
        av[6] = '{10'd17,  10'd479, 1'b1, 12'd2322};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(int'(av[i].h), int'(av[i].v), av[i].de, 1'b1, 1'b1);
            @(posedge clk);
            #1;
            check($sformatf("txt_addr[%0d]", i), 16'(txt_addr), 16'(av[i].addr));
        end
        @(negedge clk);
        drive_idle();
        repeat (8) @(negedge clk);

        // Pixel stream: glyph bits, attribute switch at cell edge, blanking
        nv = 0;
        seq = 32'hA111_111A;
        for (int i = 0; i < 8; i++) pv[nv++] = mkv(i, 0, 1'b1, seq[31-4*i -: 4], 4'h1);
        seq = 32'hCCCC_2222;
        for (int i = 0; i < 8; i++) pv[nv++] = mkv(8 + i, 0, 1'b1, seq[31-4*i -: 4], 4'h2);
        seq = 32'h11AA_AA11;
        for (int i = 0; i < 8; i++) pv[nv++] = mkv(i, 5, 1'b1, seq[31-4*i -: 4], 4'h1);
        for (int i = 0; i < 4; i++) pv[nv++] = mkv(i, 480, 1'b1, 4'h0, 4'h0);
        pv[nv++] = mkv(0, 0, 1'b0, 4'h0, 4'h0);
        pv[nv++] = mkv(1, 0, 1'b0, 4'h0, 4'h0);
        pv[nv++] = mkv(16, 479, 1'b1, 4'h6, 4'h5);
        pv[nv++] = mkv(17, 479, 1'b1, 4'h5, 4'h5);
        run_stream("pix");
        repeat (8) @(negedge clk);

        // Sync alignment: one-cycle hsync/vsync/de pulse on cell (0,0) pixel 0
        @(negedge clk);
        drive(0, 0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            drive_idle();
            check($sformatf("hsync_out@%0d", k), 16'(hsync_out), (k == 7) ? 16'd0 : 16'd1);
            check($sformatf("vsync_out@%0d", k), 16'(vsync_out), (k == 7) ? 16'd0 : 16'd1);
            check($sformatf("de_out@%0d", k),    16'(de_out),    (k == 7) ? 16'd1 : 16'd0);
            check($sformatf("align fg@%0d", k),  16'(fg),        (k == 5) ? 16'hA : 16'h0);
        end
        repeat (4) @(negedge clk);

        // Async reset mid-frame with active inputs held, then release
        @(negedge clk);
        drive(0, 0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("rel hsync_out@%0d", k), 16'(hsync_out), (k >= 7) ? 16'd0 : 16'd1);
            check($sformatf("rel de_out@%0d", k),    16'(de_out),    (k >= 7) ? 16'd1 : 16'd0);
            check($sformatf("rel fg@%0d", k),        16'(fg),        (k >= 5) ? 16'hA : 16'h0);
            check($sformatf("rel bg@%0d", k),        16'(bg),        (k >= 5) ? 16'h1 : 16'h0);
        end

`ifdef VGA_CURSOR_EN
        // Cursor at (3,2): 16 vsync entries -> visible, 32 -> hidden again
        clean_reset();
        for (int p = 0; p < 16; p++) begin
            @(negedge clk);
            drive(700, 0, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            drive_idle();
        end
        nv = 0;
        pv[nv++] = mkv(24, 46, 1'b1, 4'hF, 4'h3);
        pv[nv++] = mkv(31, 47, 1'b1, 4'hF, 4'h3);
        pv[nv++] = mkv(24, 45, 1'b1, 4'h3, 4'h3);
        pv[nv++] = mkv(32, 46, 1'b1, 4'h3, 4'h3);
        pv[nv++] = mkv(23, 46, 1'b1, 4'h3, 4'h3);
        run_stream("cur_on");
        for (int p = 0; p < 16; p++) begin
            @(negedge clk);
            drive(700, 0, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            drive_idle();
        end
        for (int i = 0; i < nv; i++) pv[i].fg = 4'h3;
        run_stream("cur_off");
`endif

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
